// File: rtl/bus_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// bus_cycle_ctrl
//   68010 bus-cycle controller for the rosco board. Each address-strobe
//   cycle is decoded once at its start into ROM, RAM, I/O or CPU space. The
//   controller drives the matching chip select, returns DTACK after the
//   region's wait count (or after the I/O device's own DTACK), and turns
//   illegal ROM writes into a bus error. Low-memory reads are shadowed to ROM
//   while the boot flag is low.
//
//   Optional feature macro: BUS_WATCHDOG_EN
//     defined   - an 8-bit watchdog turns stalled WAIT/CPUSP cycles into BERR
//                 once TIMEOUT clocks have elapsed since cycle start.
//     undefined - no watchdog; stalled cycles last until ACK or strobe release.
//
// Parameters
//   ROM_WAIT    wait clocks before DTACK for ROM cycles (0..15)
//   RAM_WAIT    wait clocks before DTACK for RAM cycles (0..15)
//   TIMEOUT     watchdog limit in clocks from cycle start (2..255)
//
// Ports
//   i_CLK        CPU clock, rising-edge sampling
//   i_RESET_n    asynchronous active-low reset
//   i_AS_n       CPU address strobe
//   i_RW_n       1 = read, 0 = write
//   i_A          address bits 23:20
//   i_FC         CPU function code
//   i_BOOT       0 = boot mapping (low reads go to ROM), 1 = normal map
//   i_IODTACK_n  DTACK from the I/O devices
//   o_ROMCS_n    ROM chip select
//   o_RAMCS_n    RAM chip select
//   o_IOCS_n     I/O chip select
//   o_DTACK_n    data acknowledge to the CPU
//   o_BERR_n     bus error to the CPU
// ---------------------------------------------------------------------------
module bus_cycle_ctrl #(
    parameter int unsigned ROM_WAIT = 2,
    parameter int unsigned RAM_WAIT = 0,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic       i_CLK,
    input  logic       i_RESET_n,
    input  logic       i_AS_n,
    input  logic       i_RW_n,
    input  logic [3:0] i_A,
    input  logic [2:0] i_FC,
    input  logic       i_BOOT,
    input  logic       i_IODTACK_n,
    output logic       o_ROMCS_n,
    output logic       o_RAMCS_n,
    output logic       o_IOCS_n,
    output logic       o_DTACK_n,
    output logic       o_BERR_n
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_BERR,
        S_CPUSP
    } state_t;

    typedef enum logic [1:0] {
        RG_ROM,
        RG_RAM,
        RG_IO,
        RG_CPU
    } region_t;

    localparam logic [3:0] LP_ROM_WAIT = 4'(ROM_WAIT);
    localparam logic [3:0] LP_RAM_WAIT = 4'(RAM_WAIT);

    state_t     r_state, w_state_nxt;
    region_t    r_region, w_region_nxt, w_region_dec;
    logic [3:0] r_wait, w_wait_nxt;
    logic       w_wd_hit;
    logic       w_ack_cond;

    // Address decode, priority order: CPU space, ROM, I/O, boot shadow, RAM.
    always_comb begin
        if (i_FC == 3'b111)
            w_region_dec = RG_CPU;
        else if (i_A == 4'hE)
            w_region_dec = RG_ROM;
        else if (i_A == 4'hF)
            w_region_dec = RG_IO;
        else if (!i_BOOT && i_A == 4'h0 && i_RW_n)
            w_region_dec = RG_ROM;
        else
            w_region_dec = RG_RAM;
    end

    // I/O cycles are paced by the device; memory cycles by the wait counter.
    assign w_ack_cond = (r_region == RG_IO) ? !i_IODTACK_n : (r_wait == 4'd0);

`ifdef BUS_WATCHDOG_EN
    localparam logic [7:0] LP_WD_LAST = 8'(TIMEOUT - 1);

    logic [7:0] r_wdog;

    // The counter reads k-1 just before edge N+k, so matching TIMEOUT-1
    // fires the transition on edge N+TIMEOUT.
    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n)
            r_wdog <= 8'd0;
        else if (r_state == S_WAIT || r_state == S_CPUSP)
            r_wdog <= r_wdog + 8'd1;
        else
            r_wdog <= 8'd0;
    end

    assign w_wd_hit = (r_state == S_WAIT || r_state == S_CPUSP) && (r_wdog == LP_WD_LAST);
`else
    assign w_wd_hit = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            r_state  <= S_IDLE;
            r_region <= RG_RAM;
            r_wait   <= 4'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_region <= w_region_nxt;
            r_wait   <= w_wait_nxt;
        end
    end

    // NOTE: every signal gets a default at the top so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_region_nxt = r_region;
        w_wait_nxt   = r_wait;
        o_ROMCS_n    = 1'b1;
        o_RAMCS_n    = 1'b1;
        o_IOCS_n     = 1'b1;
        o_DTACK_n    = 1'b1;
        o_BERR_n     = 1'b1;

        case (r_state)
            S_IDLE: begin
                if (!i_AS_n) begin
                    w_region_nxt = w_region_dec;
                    w_wait_nxt   = (w_region_dec == RG_ROM) ? LP_ROM_WAIT : LP_RAM_WAIT;
                    case (w_region_dec)
                        RG_CPU:  w_state_nxt = S_CPUSP;
                        RG_ROM:  w_state_nxt = i_RW_n ? S_WAIT : S_BERR;
                        default: w_state_nxt = S_WAIT;
                    endcase
                end
            end

            S_WAIT: begin
                // Strobe release aborts; ACK beats a simultaneous timeout.
                if (i_AS_n)
                    w_state_nxt = S_IDLE;
                else if (w_ack_cond)
                    w_state_nxt = S_ACK;
                else if (w_wd_hit)
                    w_state_nxt = S_BERR;
                else if (r_wait != 4'd0)
                    w_wait_nxt = r_wait - 4'd1;
            end

            S_CPUSP: begin
                if (i_AS_n)
                    w_state_nxt = S_IDLE;
                else if (w_wd_hit)
                    w_state_nxt = S_BERR;
            end

            S_ACK, S_BERR: begin
                if (i_AS_n)
                    w_state_nxt = S_IDLE;
            end

            default: w_state_nxt = S_IDLE;
        endcase

        // Chip select follows the latched region in WAIT and ACK only.
        if (r_state == S_WAIT || r_state == S_ACK) begin
            o_ROMCS_n = (r_region != RG_ROM);
            o_RAMCS_n = (r_region != RG_RAM);
            o_IOCS_n  = (r_region != RG_IO);
        end
        o_DTACK_n = (r_state != S_ACK);
        o_BERR_n  = (r_state != S_BERR);
    end

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bus_cycle_ctrl
//   Directed bench for bus_cycle_ctrl with default parameters
//   (ROM_WAIT = 2, RAM_WAIT = 0, TIMEOUT = 64). Simple memory cycles come
//   from a vector table; I/O, abort, reset, mid-cycle changes and CPU-space
//   cycles are hand-written sequences. Outputs are packed as
//   {ROMCS_n, RAMCS_n, IOCS_n, DTACK_n, BERR_n}.
// ---------------------------------------------------------------------------
module tb_bus_cycle_ctrl;

    localparam logic [4:0] O_IDLE    = 5'b11111;
    localparam logic [4:0] O_ROM_WT  = 5'b01111;
    localparam logic [4:0] O_ROM_ACK = 5'b01101;
    localparam logic [4:0] O_RAM_WT  = 5'b10111;
    localparam logic [4:0] O_RAM_ACK = 5'b10101;
    localparam logic [4:0] O_IO_WT   = 5'b11011;
    localparam logic [4:0] O_IO_ACK  = 5'b11001;
    localparam logic [4:0] O_BERR    = 5'b11110;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       as_n = 1'b1;
    logic       rw_n = 1'b1;
    logic [3:0] a = 4'h0;
    logic [2:0] fc = 3'b101;
    logic       boot = 1'b1;
    logic       iodtack_n = 1'b1;
    logic       romcs_n, ramcs_n, iocs_n, dtack_n, berr_n;

    int n_cmp = 0;
    int n_bad = 0;

    bus_cycle_ctrl #(
        .ROM_WAIT (2),
        .RAM_WAIT (0),
        .TIMEOUT  (64)
    ) dut (
        .i_CLK       (clk),
        .i_RESET_n   (rst_n),
        .i_AS_n      (as_n),
        .i_RW_n      (rw_n),
        .i_A         (a),
        .i_FC        (fc),
        .i_BOOT      (boot),
        .i_IODTACK_n (iodtack_n),
        .o_ROMCS_n   (romcs_n),
        .o_RAMCS_n   (ramcs_n),
        .o_IOCS_n    (iocs_n),
        .o_DTACK_n   (dtack_n),
        .o_BERR_n    (berr_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [2:0] fc;
        logic       rw_n;
        logic       boot;
        logic [4:0] exp_n;    // outputs right after edge N
        logic [4:0] exp_ack;  // outputs once DTACK is due
        int         n_wait;   // wait clocks; -1 = bus-error cycle
        string      name;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [4:0] exp);
        logic [4:0] act;
        act = {romcs_n, ramcs_n, iocs_n, dtack_n, berr_n};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Run one complete cycle from a vector; strobe released once DTACK or
    // BERR is seen, and the next cycle may start on the following edge.
    task automatic run_cycle(input vec_t v);
        as_n = 1'b0;
        a    = v.a;
        fc   = v.fc;
        rw_n = v.rw_n;
        boot = v.boot;
        tick();
        check({v.name, " @N"}, v.exp_n);
        for (int k = 1; k <= v.n_wait + 1; k++) begin
            tick();
            check($sformatf("%s @N+%0d", v.name, k), (k == v.n_wait + 1) ? v.exp_ack : v.exp_n);
        end
        as_n = 1'b1;
        tick();
        check({v.name, " end"}, O_IDLE);
    endtask

    vec_t vecs[8];
    vec_t rom_rd;

    initial begin
        vecs[0] = '{4'hE, 3'b101, 1'b1, 1'b1, O_ROM_WT, O_ROM_ACK,  2, "rom_rd_E00000"};
        vecs[1] = '{4'h0, 3'b110, 1'b1, 1'b0, O_ROM_WT, O_ROM_ACK,  2, "boot_shadow_rd"};
        vecs[2] = '{4'h0, 3'b101, 1'b0, 1'b0, O_RAM_WT, O_RAM_ACK,  0, "boot_low_wr"};
        vecs[3] = '{4'h0, 3'b101, 1'b1, 1'b1, O_RAM_WT, O_RAM_ACK,  0, "normal_low_rd"};
        vecs[4] = '{4'hE, 3'b101, 1'b0, 1'b1, O_BERR,   O_BERR,    -1, "rom_wr_berr"};
        vecs[5] = '{4'h5, 3'b001, 1'b1, 1'b0, O_RAM_WT, O_RAM_ACK,  0, "ram_rd_boot0"};
        vecs[6] = '{4'hE, 3'b110, 1'b0, 1'b0, O_BERR,   O_BERR,    -1, "rom_wr_boot0"};
        vecs[7] = '{4'h0, 3'b101, 1'b0, 1'b1, O_RAM_WT, O_RAM_ACK,  0, "ram_wr"};
        rom_rd  = vecs[0];

        // Reset state: a real falling edge on reset, checked before any clock.
        #2 rst_n = 1'b0;
        #1 check("reset_state", O_IDLE);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("after_release", O_IDLE);

        // Table-driven memory and bus-error cycles, run back to back.
        foreach (vecs[i]) run_cycle(vecs[i]);

        // I/O read: device DTACK sampled low on edge N+5, DTACK out after it.
        as_n = 1'b0; a = 4'hF; fc = 3'b101; rw_n = 1'b1; boot = 1'b1;
        tick();
        check("io @N", O_IO_WT);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("io @N+%0d", k), O_IO_WT);
        end
        iodtack_n = 1'b0;
        tick();
        check("io ack @N+5", O_IO_ACK);
        as_n = 1'b1;
        iodtack_n = 1'b1;
        tick();
        check("io end", O_IDLE);

        // Region latched at cycle start: mid-cycle input changes are ignored.
        as_n = 1'b0; a = 4'hE; fc = 3'b101; rw_n = 1'b1; boot = 1'b1;
        tick();
        check("latch @N", O_ROM_WT);
        a = 4'hF; fc = 3'b111; boot = 1'b0;
        tick();
        check("latch @N+1", O_ROM_WT);
        tick();
        check("latch @N+2", O_ROM_WT);
        tick();
        check("latch @N+3", O_ROM_ACK);
        as_n = 1'b1;
        tick();
        check("latch end", O_IDLE);

        // Strobe released during WAIT aborts the cycle.
        as_n = 1'b0; a = 4'hE; fc = 3'b101; rw_n = 1'b1;
        tick();
        check("abort @N", O_ROM_WT);
        as_n = 1'b1;
        tick();
        check("abort idle", O_IDLE);

        // Reset mid-WAIT negates outputs immediately, then a clean restart.
        as_n = 1'b0;
        tick();
        check("rst_mid @N", O_ROM_WT);
        #2 rst_n = 1'b0;
        #1 check("rst_mid async", O_IDLE);
        as_n = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        run_cycle(rom_rd);

        // CPU space (FC=7 beats the ROM address): nothing driven.
        as_n = 1'b0; a = 4'hE; fc = 3'b111; rw_n = 1'b1;
        tick();
        check("cpusp @N", O_IDLE);
        for (int k = 1; k < 64; k++) begin
            tick();
            check($sformatf("cpusp @N+%0d", k), O_IDLE);
        end
        tick();
`ifdef BUS_WATCHDOG_EN
        check("cpusp timeout @N+64", O_BERR);
`else
        check("cpusp no_wdog @N+64", O_IDLE);
`endif
        as_n = 1'b1;
        tick();
        check("cpusp end", O_IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_cycle_ctrl.md
# bus_cycle_ctrl

68010 bus-cycle controller for the rosco board: samples each address-strobe cycle, decodes it to ROM, RAM, I/O or CPU space, drives the matching chip select and generates DTACK after a per-region wait count. A watchdog converts stalled cycles into a bus error. It sits beside the reset/boot glue and consumes its boot flag so that low-memory reads fetch from ROM until boot completes.

## Interface

Parameters:
- ROM_WAIT, 2: wait cycles before DTACK for ROM cycles (0..15).
- RAM_WAIT, 0: wait cycles before DTACK for RAM cycles (0..15).
- TIMEOUT, 64: watchdog limit in clocks from cycle start (2..255).

Ports:
- i_CLK  in  1  CPU clock; all sampling on the rising edge.
- i_RESET_n  in  1  asynchronous, active-low reset.
- i_AS_n  in  1  CPU address strobe, synchronous to i_CLK.
- i_RW_n  in  1  1 = read, 0 = write.
- i_A  in  [23:20]  upper address bits.
- i_FC  in  [2:0]  CPU function code.
- i_BOOT  in  1  0 = boot mapping active; 1 = normal map.
- i_IODTACK_n  in  1  DTACK from I/O devices (DUART).
- o_ROMCS_n  out  1  ROM chip select.
- o_RAMCS_n  out  1  RAM chip select.
- o_IOCS_n  out  1  I/O chip select.
- o_DTACK_n  out  1  data acknowledge to the CPU.
- o_BERR_n  out  1  bus error to the CPU.

## Operation

- Decode happens in IDLE on the edge that samples i_AS_n = 0. Region priority:
  1. i_FC = 3'b111 → CPU space.
  2. i_A = 4'hE → ROM.
  3. i_A = 4'hF → IO.
  4. i_BOOT = 0, i_A = 4'h0 and i_RW_n = 1 → ROM (boot shadow).
  5. Otherwise → RAM.
- A ROM write is illegal and goes straight to BERR; no chip select is asserted.
- States:
  - IDLE: all outputs negated.
  - WAIT: chip select asserted, wait counter loaded.
  - ACK: chip select and o_DTACK_n asserted.
  - BERR: o_BERR_n asserted, no chip select.
  - CPUSP: nothing driven; DTACK for interrupt acknowledge comes from outside.
- WAIT, ROM/RAM: the wait counter decrements each clock. When it is 0, move to ACK.
- WAIT, IO: stay until i_IODTACK_n is sampled 0, then move to ACK. o_DTACK_n is asserted one clock after i_IODTACK_n is sampled low.
- ACK and BERR hold until i_AS_n is sampled 1, then return to IDLE. All outputs negate on that edge.
- i_AS_n sampled 1 while in WAIT or CPUSP aborts the cycle: return to IDLE and negate everything.
- Watchdog: an 8-bit counter cleared in IDLE, incremented every clock in WAIT and CPUSP. When it reaches TIMEOUT, move to BERR. A timeout and an ACK condition on the same edge resolve to ACK.
- The region is latched at cycle start. Changes on i_A, i_FC or i_BOOT mid-cycle are ignored.

## Timing

- Reset value of every output is 1 (negated); the state is IDLE and both counters are 0.
- Cycle start is edge N, where i_AS_n is first sampled 0:
  - Chip select asserts after edge N.
  - o_DTACK_n asserts after edge N+1+W, with W = ROM_WAIT or RAM_WAIT.
  - With RAM_WAIT = 0, DTACK follows one clock after the strobe is sampled.
- BERR for a ROM write asserts after edge N.
- BERR on timeout asserts after edge N+TIMEOUT.
- Cycle end: outputs negate after the first edge that samples i_AS_n = 1.
- Back-to-back cycles: i_AS_n sampled 0 on the edge after returning to IDLE starts a new cycle with no extra gap.
- Reset is asynchronous. Asserting i_RESET_n mid-cycle negates all outputs immediately and forces IDLE. Release is synchronous to the next i_CLK edge.

## Configuration

- BUS_WATCHDOG_EN defined: the watchdog and timeout-to-BERR path are built as described above.
- BUS_WATCHDOG_EN undefined:
  - No watchdog counter is built.
  - WAIT and CPUSP persist until ACK or until i_AS_n is sampled 1.
  - o_BERR_n still asserts for ROM writes.

## Test plan

- Reset asserted mid-WAIT (ROM read) → all outputs 1 immediately; after release, next strobe starts cleanly in IDLE.
- ROM read at 0xE00000, ROM_WAIT = 2 → o_ROMCS_n low from edge N, o_DTACK_n low from edge N+3; both go high one edge after i_AS_n rises.
- i_BOOT = 0: read at 0x000004 → o_ROMCS_n; write at 0x000004 → o_RAMCS_n. After i_BOOT = 1, the read → o_RAMCS_n with DTACK at N+1.
- IO read at 0xF00001 with i_IODTACK_n low 5 clocks after start → o_IOCS_n low from N, o_DTACK_n low one clock after the sample, no BERR.
- Write at 0xE00010 → o_BERR_n low from N, o_ROMCS_n stays 1.
- i_FC = 3'b111 cycle with no external DTACK, TIMEOUT = 64:
  - Watchdog enabled → o_BERR_n low after edge N+64.
  - BUS_WATCHDOG_EN undefined → no BERR, returns to IDLE when i_AS_n rises.
